sha1_arb: RTL and testbench

Shares a single SHA-1 compression core between `NREQ` requesters with round-robin fairness. Each requester presents one padded 512-bit block. The arbiter captures the winning block, starts the core, and waits for completion. It then returns the 160-bit digest, tagged with the requester index, over a back-pressured response port. It sits between the host-side request sources and the SHA-1 core, and it is the only block that drives the core's start and data inputs.

---
 rtl/sha1_pkg.sv | 18 +
 rtl/sha1_rr_pick.sv | 28 ++
 rtl/sha1_arb.sv | 109 ++++++++++
 tb/tb_sha1_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared SHA-1 widths, IV and arbiter state encoding
package sha1_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 160;

  // Initial hash value H0..H4, shared with the compression core
  localparam logic [DIGEST_W-1:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } sha1_arb_state_t;

endpackage

// File: rtl/sha1_rr_pick.sv
// rtl/sha1_rr_pick.sv - combinational round-robin picker
// The first set request at or after ptr wins, wrapping modulo NREQ.
module sha1_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    any   = |req;
    // Walk from the farthest offset down so the nearest request wins last
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) idx = IDW'(j);
    end
    grant = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sha1_arb.sv
// rtl/sha1_arb.sv - round-robin sharing of one SHA-1 core between NREQ requesters
// Captures the winning block, starts the core, returns the tagged digest or a timeout.
module sha1_arb
  import sha1_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*BLOCK_W-1:0] req_block,
  output logic [NREQ-1:0]         req_ready,
  output logic                    core_start,
  output logic [BLOCK_W-1:0]      core_block,
  input  logic                    core_done,
  input  logic [DIGEST_W-1:0]     core_digest,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [DIGEST_W-1:0]     rsp_digest,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  sha1_arb_state_t       state;
  logic [IDW-1:0]        ptr;
  logic [BLOCK_W-1:0]    blk_q;
  logic [IDW-1:0]        id_q;
  logic [DIGEST_W-1:0]   dig_q;
  logic                  err_q;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;

  logic [NREQ-1:0]       pick_grant;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_any;

  sha1_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Saturating so the count can never wrap back below TIMEOUT
  assign cnt_inc = (cnt == TMAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= '0;
      blk_q      <= '0;
      id_q       <= '0;
      dig_q      <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
      core_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            blk_q      <= req_block[int'(pick_idx)*BLOCK_W +: BLOCK_W];
            id_q       <= pick_idx;
            ptr        <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          cnt        <= '0;
          state      <= BUSY;
        end
        BUSY: begin
          cnt <= cnt_inc;
          // Completion takes priority over a timeout landing in the same cycle
          if (core_done) begin
            dig_q <= core_digest;
            err_q <= 1'b0;
            state <= RESP;
          end else if (cnt_inc == TMAX) begin
            dig_q <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE) ? pick_grant : '0;
  assign core_block = blk_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_digest = dig_q;
  assign rsp_err    = err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sha1_arb.sv
// tb/tb_sha1_arb.sv - directed bench for sha1_arb with a latency-programmable core stub
module tb_sha1_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*512-1:0]  req_block = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 core_start;
  logic [511:0]         core_block;
  logic                 core_done;
  logic [159:0]         core_digest;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [159:0]         rsp_digest;
  logic                 rsp_err;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_v = 10;
  int cd;

  logic [511:0] blocks [NREQ];
  logic [159:0] dig_tab [NREQ];

  always #5 CLK = ~CLK;

  sha1_arb #(.NREQ(NREQ), .TIMEOUT(20), .IDW(IDW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_block   (req_block),
    .req_ready   (req_ready),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_digest (core_digest),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_digest  (rsp_digest),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // Core stub: done lat_v cycles after start (0 = never), digest looked up by block
  function automatic logic [159:0] stub_digest(input logic [511:0] b);
    logic [159:0] d;
    d = 160'hbad0bad0bad0bad0bad0bad0bad0bad0bad0bad0;
    for (int i = 0; i < NREQ; i++)
      if (b == blocks[i]) d = dig_tab[i];
    return d;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cd          <= 0;
      core_done   <= 1'b0;
      core_digest <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start && lat_v != 0) begin
        if (lat_v == 1) begin
          core_done   <= 1'b1;
          core_digest <= stub_digest(core_block);
        end else begin
          cd <= lat_v - 1;
        end
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          core_done   <= 1'b1;
          core_digest <= stub_digest(core_block);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] mask;
    int         lat;
    int         idx;
    bit         err;
  } vec_t;

  // One full job: grant in cycle 0, start in cycle 1, response at lat+2 (22 on timeout)
  task automatic run_job(input vec_t v);
    int cyc;
    int exp_lat;
    if (v.rst) begin
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
    end
    lat_v     = v.lat;
    req_valid = v.mask;
    #1;
    chk("grant", req_ready, 512'(1) << v.idx);
    @(negedge CLK);
    req_valid = '0;
    chk("start", core_start, 1);
    chk("core_block", core_block, blocks[v.idx]);
    @(negedge CLK);
    chk("start_pulse", core_start, 0);
    cyc = 2;
    while (!rsp_valid && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    exp_lat = (v.lat == 0) ? 22 : v.lat + 2;
    chk("rsp_latency", cyc, exp_lat);
    chk("rsp_id", rsp_id, v.idx);
    chk("rsp_digest", rsp_digest, v.err ? 160'h0 : dig_tab[v.idx]);
    chk("rsp_err", rsp_err, v.err);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("back_idle", {busy, rsp_valid}, 0);
  endtask

  vec_t tab [13];

  initial begin
    bit ok;
    blocks[0]  = {16{32'h11111111}};
    blocks[1]  = {32'h80000000, 480'h0};
    blocks[2]  = {32'h61626380, 448'h0, 32'h00000018};
    blocks[3]  = {16{32'h33333333}};
    dig_tab[0] = 160'h0123456789abcdef0123456789abcdef01234567;
    dig_tab[1] = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    dig_tab[2] = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    dig_tab[3] = 160'hfedcba9876543210fedcba9876543210fedcba98;
    for (int i = 0; i < NREQ; i++) req_block[i*512 +: 512] = blocks[i];

    tab[0]  = '{1, 4'b0100, 10, 2, 0};
    tab[1]  = '{1, 4'b1111, 10, 0, 0};
    tab[2]  = '{0, 4'b1111, 10, 1, 0};
    tab[3]  = '{0, 4'b1111, 10, 2, 0};
    tab[4]  = '{0, 4'b1111, 10, 3, 0};
    tab[5]  = '{0, 4'b1111, 10, 0, 0};
    tab[6]  = '{0, 4'b1010, 10, 1, 0};
    tab[7]  = '{0, 4'b1001, 10, 3, 0};
    tab[8]  = '{0, 4'b0001, 10, 0, 0};
    tab[9]  = '{0, 4'b0001, 10, 0, 0};
    tab[10] = '{0, 4'b0010,  0, 1, 1};
    tab[11] = '{0, 4'b0100, 20, 2, 0};
    tab[12] = '{0, 4'b1000, 19, 3, 0};

    RST = 1'b1;
    #1;
    chk("reset_outputs", {req_ready, core_start, rsp_valid, rsp_id, rsp_err, busy}, 0);
    chk("reset_digest", rsp_digest, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int k = 0; k < 13; k++) run_job(tab[k]);

    // Back-pressure with requester 3 toggling during BUSY and then held into IDLE
    lat_v     = 10;
    req_valid = 4'b0001;
    #1;
    chk("bp_grant", req_ready, 4'b0001);
    @(negedge CLK);
    req_valid = '0;
    ok = 1'b1;
    for (int c = 2; c < 12; c++) begin
      @(negedge CLK);
      req_valid = c[0] ? 4'b1000 : 4'b0000;
      #1;
      if (req_ready != 0 || !busy) ok = 1'b0;
    end
    chk("busy_no_ready", ok, 1);
    req_valid = 4'b1000;
    @(negedge CLK);
    chk("bp_rsp_valid", rsp_valid, 1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!rsp_valid || rsp_id != 0 || rsp_digest != dig_tab[0] || rsp_err
          || req_ready != 0 || core_start) ok = 1'b0;
      @(negedge CLK);
    end
    chk("bp_stable", ok, 1);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    run_job('{0, 4'b1000, 10, 3, 0});

    // Reset in the middle of BUSY
    lat_v     = 0;
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", req_ready, 4'b0100);
    @(negedge CLK);
    req_valid = '0;
    repeat (10) @(negedge CLK);
    chk("mid_busy", busy, 1);
    RST = 1'b1;
    #1;
    chk("mid_reset_ctl", {req_ready, core_start, rsp_valid, rsp_id, rsp_err, busy}, 0);
    chk("mid_reset_data", {core_block, rsp_digest}, 0);
    @(negedge CLK);
    RST = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (rsp_valid || busy) ok = 1'b0;
    end
    chk("no_rsp_after_reset", ok, 1);
    run_job('{0, 4'b1001, 10, 0, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
